// File: rtl/fft_mag_writer_if.sv
// rtl/fft_mag_writer_if.sv - FFT core output stream bundle (tdata/tvalid/tlast/tready)
interface fft_mag_writer_if;
  logic [31:0] fft_tdata;
  logic        fft_tvalid;
  logic        fft_tlast;
  logic        fft_tready;

  modport master (output fft_tdata, fft_tvalid, fft_tlast, input fft_tready);
  modport slave  (input fft_tdata, fft_tvalid, fft_tlast, output fft_tready);
endinterface

// File: rtl/fft_mag_writer.sv
// rtl/fft_mag_writer.sv - FFT bin magnitude writer into the sampler's BRAM; DC_BLANK_EN zeroes low bins
module fft_mag_writer #(
  parameter int FRAME_LEN     = 1024,
  parameter int ADDR_W        = 10,
  parameter int DC_BLANK_BINS = 4
) (
  input  logic              clk,
  input  logic              rst,
  fft_mag_writer_if.slave   fft,
  input  logic              sampler_done,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic              wr_en,
  output logic              sampler_start,
  output logic [7:0]        frames_dropped,
  output logic [7:0]        framing_errors
);
  typedef enum logic [1:0] {SYNC, ARMED, CAPTURE, DROP} state_t;

  localparam logic [ADDR_W-1:0] LAST_BIN  = ADDR_W'(FRAME_LEN - 1);
  localparam logic [ADDR_W-1:0] BLANK_LIM = ADDR_W'(DC_BLANK_BINS);
`ifdef DC_BLANK_EN
  localparam logic BLANK_EN = 1'b1;
`else
  localparam logic BLANK_EN = 1'b0;
`endif

  state_t            state;
  logic [ADDR_W-1:0] bin;
  logic              start_pending, start_d1, start_d2;
  logic [15:0]       a1, b1;
  logic [ADDR_W-1:0] addr1;
  logic              cap1, blank1;
  logic              beat, sample_ok, take;
  logic [15:0]       re, im, mx, mn;

  assign fft.fft_tready = !rst;
  assign beat      = fft.fft_tvalid && fft.fft_tready;
  assign re        = fft.fft_tdata[15:0];
  assign im        = fft.fft_tdata[31:16];
  assign sample_ok = sampler_done && !start_pending;
  assign take      = beat && (state == CAPTURE || (state == ARMED && sample_ok));
  assign mx        = (a1 > b1) ? a1 : b1;
  assign mn        = (a1 > b1) ? b1 : a1;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= SYNC;
      bin            <= '0;
      start_pending  <= 1'b0;
      start_d1       <= 1'b0;
      start_d2       <= 1'b0;
      sampler_start  <= 1'b0;
      a1             <= '0;
      b1             <= '0;
      addr1          <= '0;
      cap1           <= 1'b0;
      blank1         <= 1'b0;
      wr_en          <= 1'b0;
      wr_addr        <= '0;
      wr_data        <= '0;
      frames_dropped <= '0;
      framing_errors <= '0;
    end else begin
      // Stage 1: absolute values; the unsigned 16-bit negate maps -32768 to 32768.
      cap1   <= take;
      addr1  <= bin;
      blank1 <= BLANK_EN && (bin < BLANK_LIM);
      a1     <= re[15] ? -re : re;
      b1     <= im[15] ? -im : im;
      wr_en  <= cap1;
      if (cap1) begin
        wr_addr <= addr1;
        wr_data <= blank1 ? 16'd0 : mx + (mn >> 2);
      end
      // Start trails the last write by one cycle; pending covers the gap until then.
      start_d1      <= 1'b0;
      start_d2      <= start_d1;
      sampler_start <= start_d2;
      if (start_d2) start_pending <= 1'b0;

      if (beat) begin
        case (state)
          SYNC: if (fft.fft_tlast) state <= ARMED;
          ARMED: begin
            if (!sample_ok) begin
              if (fft.fft_tlast) frames_dropped <= sat_inc(frames_dropped);
              else               state <= DROP;
            end else if (fft.fft_tlast) begin
              framing_errors <= sat_inc(framing_errors);
            end else begin
              bin   <= bin + 1'b1;
              state <= CAPTURE;
            end
          end
          CAPTURE: begin
            if (fft.fft_tlast) begin
              if (bin == LAST_BIN) begin
                start_pending <= 1'b1;
                start_d1      <= 1'b1;
              end else begin
                framing_errors <= sat_inc(framing_errors);
              end
              bin   <= '0;
              state <= ARMED;
            end else if (bin == LAST_BIN) begin
              framing_errors <= sat_inc(framing_errors);
              bin   <= '0;
              state <= SYNC;
            end else begin
              bin <= bin + 1'b1;
            end
          end
          DROP: begin
            if (fft.fft_tlast) begin
              frames_dropped <= sat_inc(frames_dropped);
              state          <= ARMED;
            end
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_fft_mag_writer.sv
// tb/tb_fft_mag_writer.sv - self-checking bench for fft_mag_writer
module tb_fft_mag_writer;
  localparam int N    = 1024;
  localparam int MAXC = 65536;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sampler_done = 1'b1;
  logic [9:0]  wr_addr;
  logic [15:0] wr_data;
  logic        wr_en, sampler_start;
  logic [7:0]  frames_dropped, framing_errors;

  fft_mag_writer_if fft_bus();

  fft_mag_writer dut (
    .clk            (clk),
    .rst            (rst),
    .fft            (fft_bus),
    .sampler_done   (sampler_done),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .wr_en          (wr_en),
    .sampler_start  (sampler_start),
    .frames_dropped (frames_dropped),
    .framing_errors (framing_errors)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  bit          exp_we    [MAXC];
  logic [9:0]  exp_addr  [MAXC];
  logic [15:0] exp_data  [MAXC];
  bit          exp_start [MAXC];
  logic [15:0] ram [N];
  int wr_count = 0;
  int start_count = 0;

  // Frame-level model: 0 sync, 1 armed, 2 capture, 3 drop
  int m_mode = 0, m_bin = 0, m_good_t = -100, m_drop = 0, m_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int sat(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  function automatic logic [15:0] model_mag(input logic [31:0] d, input int b);
    int re, im, a, c;
    re = $signed(d[15:0]);
    im = $signed(d[31:16]);
    a  = (re < 0) ? -re : re;
    c  = (im < 0) ? -im : im;
`ifdef DC_BLANK_EN
    if (b < 4) return 16'd0;
`endif
    return 16'((a > c) ? a + c / 4 : c + a / 4);
  endfunction

  task automatic model_write(input int n, input int b, input logic [31:0] d);
    exp_we[n + 2]   = 1'b1;
    exp_addr[n + 2] = 10'(b);
    exp_data[n + 2] = model_mag(d, b);
  endtask

  task automatic model_beat(input int n, input logic [31:0] d, input bit last, input bit done);
    bit pending;
    case (m_mode)
      0: if (last) m_mode = 1;
      1: begin
        pending = (n - m_good_t >= 1) && (n - m_good_t <= 2);
        if (done && !pending) begin
          model_write(n, 0, d);
          if (last) m_err++;
          else begin m_bin = 1; m_mode = 2; end
        end else if (last) m_drop++;
        else m_mode = 3;
      end
      2: begin
        model_write(n, m_bin, d);
        if (last) begin
          if (m_bin == N - 1) begin m_good_t = n; exp_start[n + 3] = 1'b1; end
          else m_err++;
          m_bin = 0; m_mode = 1;
        end else if (m_bin == N - 1) begin
          m_err++; m_bin = 0; m_mode = 0;
        end else m_bin++;
      end
      default: if (last) begin m_drop++; m_mode = 1; end
    endcase
  endtask

  always @(negedge clk) begin
    check("tready", fft_bus.fft_tready, !rst);
    check("wr_en", wr_en, exp_we[cyc]);
    if (wr_en && exp_we[cyc]) begin
      check("wr_addr", wr_addr, exp_addr[cyc]);
      check("wr_data", wr_data, exp_data[cyc]);
    end
    check("sampler_start", sampler_start, exp_start[cyc]);
    if (wr_en) begin ram[wr_addr] = wr_data; wr_count++; end
    if (sampler_start) start_count++;
  end

  task automatic idle(input int n);
    fft_bus.fft_tvalid = 1'b0;
    fft_bus.fft_tlast  = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int ncyc);
    fft_bus.fft_tvalid = 1'b0;
    fft_bus.fft_tlast  = 1'b0;
    rst = 1'b1;
    for (int k = cyc + 1; k < MAXC; k++) begin exp_we[k] = 1'b0; exp_start[k] = 1'b0; end
    m_mode = 0; m_bin = 0; m_good_t = -100; m_drop = 0; m_err = 0;
    repeat (ncyc) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  function automatic logic [31:0] frame_data(input int f, input int i, input int kind);
    logic [15:0] re, im;
    re = 16'(i * 331 + f * 4099 - 20000);
    im = 16'(f * 977 - i * 613);
    if (kind == 1 && i == 0) begin re = 16'd0; im = 16'd0; end
    if (kind == 1 && i == 5) begin re = 16'(3000); im = 16'(-4000); end
    if (kind == 1 && i == 6) begin re = 16'h8000; im = 16'h8000; end
    if (kind == 2 && i < 5)  begin re = 16'd1000; im = 16'd0; end
    return {im, re};
  endfunction

  task automatic send_frame(input int f, input int nbeats, input int last_at, input bit done,
                            input int idle_pct, input int kind, input int rst_at);
    logic [31:0] d;
    sampler_done = done;
    for (int i = 0; i < nbeats; i++) begin
      if (i == rst_at) begin do_reset(1); return; end
      while (int'($urandom_range(99)) < idle_pct) begin
        fft_bus.fft_tvalid = 1'b0;
        @(posedge clk);
        #1;
      end
      d = frame_data(f, i, kind);
      fft_bus.fft_tdata  = d;
      fft_bus.fft_tvalid = 1'b1;
      fft_bus.fft_tlast  = (i == last_at);
      model_beat(cyc, d, i == last_at, done);
      @(posedge clk);
      #1;
    end
    fft_bus.fft_tvalid = 1'b0;
    fft_bus.fft_tlast  = 1'b0;
  endtask

  task automatic check_counters(input string tag, input int lit_drop, input int lit_err);
    check({tag, "_dropped_model"}, frames_dropped, sat(m_drop));
    check({tag, "_errors_model"}, framing_errors, sat(m_err));
    check({tag, "_dropped"}, frames_dropped, lit_drop);
    check({tag, "_errors"}, framing_errors, lit_err);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: got cycle %0d expected completion", cyc);
    $fatal(1);
  end

  initial begin
    fft_bus.fft_tdata  = '0;
    fft_bus.fft_tvalid = 1'b0;
    fft_bus.fft_tlast  = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("rst_wr_en", wr_en, 0);
    check("rst_start", sampler_start, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_tready", fft_bus.fft_tready, 0);
    rst = 1'b0;
    #1;
    check_counters("reset", 0, 0);

    // Sync frame is discarded, next frame captured with literal magnitudes.
    send_frame(0, N, N - 1, 1'b1, 0, 0, -1);
    idle(6);
    check("sync_no_writes", wr_count, 0);
    send_frame(1, N, N - 1, 1'b1, 0, 1, -1);
    idle(6);
    check("frame1_writes", wr_count, 1024);
    check("frame1_starts", start_count, 1);
    check("mag_zero", ram[0], 0);
    check("mag_3000_m4000", ram[5], 4750);
    check("mag_full_neg", ram[6], 40960);

    // Busy sampler drops a frame; then a frame right after a good one hits start_pending.
    send_frame(2, N, N - 1, 1'b0, 0, 0, -1);
    idle(6);
    check("busy_no_writes", wr_count, 1024);
    check_counters("busy", 1, 0);
    send_frame(3, N, N - 1, 1'b1, 0, 0, -1);
    send_frame(4, N, N - 1, 1'b1, 0, 0, -1);
    idle(6);
    check("pending_writes", wr_count, 2048);
    check("pending_starts", start_count, 2);
    check_counters("pending", 2, 0);

    // Framing errors: early tlast, then a full frame with no tlast (back to sync).
    send_frame(5, 501, 500, 1'b1, 0, 0, -1);
    idle(6);
    check_counters("early_last", 2, 1);
    send_frame(6, N, N - 1, 1'b1, 0, 0, -1);
    idle(6);
    send_frame(7, N, -1, 1'b1, 0, 0, -1);
    idle(6);
    check_counters("no_last", 2, 2);
    check("no_last_writes", wr_count, 4597);
    send_frame(8, N, N - 1, 1'b1, 0, 0, -1);
    idle(6);
    check("resync_no_writes", wr_count, 4597);
    send_frame(9, N, N - 1, 1'b1, 0, 0, -1);
    idle(6);
    check("resync_writes", wr_count, 5621);
    check("resync_starts", start_count, 4);

    // Idle gaps, then reset mid-frame at bin 700.
    send_frame(10, N, N - 1, 1'b1, 30, 0, -1);
    idle(6);
    check("gap_writes", wr_count, 6645);
    check("gap_starts", start_count, 5);
    send_frame(11, N, N - 1, 1'b1, 30, 0, 700);
    idle(6);
    check("midrst_writes", wr_count, 7344);
    check("midrst_starts", start_count, 5);
    check_counters("midrst", 0, 0);

    send_frame(12, N, N - 1, 1'b1, 0, 0, -1);
    idle(6);
    send_frame(13, N, N - 1, 1'b1, 0, 2, -1);
    idle(6);
    check("final_writes", wr_count, 8368);
    check("final_starts", start_count, 6);
`ifdef DC_BLANK_EN
    for (int i = 0; i < 4; i++) check("dc_blank_bin", ram[i], 0);
`else
    for (int i = 0; i < 4; i++) check("dc_bin", ram[i], 1000);
`endif
    check("bin4", ram[4], 1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
